// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel-rate divider, horizontal/vertical counters,
// registered sync outputs and a run/drain/idle controller that lets the
// current frame finish before stopping.
// Optional feature macro: VGA_TIMING_FRAME_CNT_EN adds a 16-bit frame_count
// output that counts frame_start pulses.
module vga_timing_gen #(
  parameter int HD   = 640,
  parameter int HF   = 16,
  parameter int HB   = 48,
  parameter int HR   = 96,
  parameter int VD   = 480,
  parameter int VF   = 10,
  parameter int VB   = 33,
  parameter int VR   = 2,
  parameter int DIV  = 4,
  parameter bit HPOL = 1'b0,
  parameter bit VPOL = 1'b0,
  parameter int CW   = 10
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          enable,
  output logic          pix_tick,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic [CW-1:0] pixel_x,
  output logic [CW-1:0] pixel_y,
  output logic          line_start,
  output logic          frame_start,
  output logic          running
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0]   frame_count
`endif
);

  localparam int HT = HD + HF + HB + HR;
  localparam int VT = VD + VF + VB + VR;
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [DW-1:0] DIV_MAX  = DW'(DIV - 1);
  localparam logic [CW-1:0] H_LAST   = CW'(HT - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(VT - 1);
  localparam logic [CW-1:0] H_DISP   = CW'(HD);
  localparam logic [CW-1:0] V_DISP   = CW'(VD);
  localparam logic [CW-1:0] HS_FIRST = CW'(HD + HF);
  localparam logic [CW-1:0] HS_LAST  = CW'(HD + HF + HR - 1);
  localparam logic [CW-1:0] VS_FIRST = CW'(VD + VF);
  localparam logic [CW-1:0] VS_LAST  = CW'(VD + VF + VR - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [CW-1:0] px_q, px_d;
  logic [CW-1:0] py_q, py_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;

  logic active;
  logic tick;
  logic h_end;
  logic v_end;

  // Decode of the current position and pixel-rate strobe.
  always_comb begin
    active = (state_q != IDLE);
    tick   = active && (div_q == DIV_MAX);
    h_end  = (px_q == H_LAST);
    v_end  = (py_q == V_LAST);
  end

  // Controller next state; enable wins over the end-of-frame stop in DRAIN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = RUN;
      RUN:     if (!enable) state_d = DRAIN;
      DRAIN: begin
        if (enable) begin
          state_d = RUN;
        end else if (tick && h_end && v_end) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Divider and pixel counters; everything is parked at zero while idle.
  always_comb begin
    div_d = div_q;
    px_d  = px_q;
    py_d  = py_q;
    if (!active) begin
      div_d = '0;
      px_d  = '0;
      py_d  = '0;
    end else begin
      div_d = (div_q == DIV_MAX) ? '0 : div_q + 1'b1;
      if (tick) begin
        px_d = h_end ? '0 : px_q + 1'b1;
        if (h_end) begin
          py_d = v_end ? '0 : py_q + 1'b1;
        end
      end
    end
  end

  // Sync levels computed from the current counters, taking effect one clk later.
  always_comb begin
    hsync_d = (active && (px_q >= HS_FIRST) && (px_q <= HS_LAST)) ? HPOL : ~HPOL;
    vsync_d = (active && (py_q >= VS_FIRST) && (py_q <= VS_LAST)) ? VPOL : ~VPOL;
  end

  // Single state register for the controller, counters and syncs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      px_q    <= '0;
      py_q    <= '0;
      hsync_q <= ~HPOL;
      vsync_q <= ~VPOL;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      px_q    <= px_d;
      py_q    <= py_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end

  // Output drive; strobes are derived from registered state only.
  always_comb begin
    running     = active;
    pix_tick    = tick;
    pixel_x     = px_q;
    pixel_y     = py_q;
    hsync       = hsync_q;
    vsync       = vsync_q;
    video_on    = (px_q < H_DISP) && (py_q < V_DISP) && active;
    line_start  = tick && (px_q == '0);
    frame_start = tick && (px_q == '0) && (py_q == '0);
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_count_q, frame_count_d;

  // Frame counter advances on each frame start and wraps naturally at 16 bits.
  always_comb begin
    frame_count_d = frame_count_q;
    if (frame_start) begin
      frame_count_d = frame_count_q + 16'd1;
    end
  end

  // Frame counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_count_q <= '0;
    end else begin
      frame_count_q <= frame_count_d;
    end
  end

  assign frame_count = frame_count_q;
`endif

endmodule
